hardware_rx: RTL and testbench

//  Oversampling serial bit receiver for the optical link front end.

---
 rtl/hardware_rx.sv | 116 +++++++++++
 tb/tb_hardware_rx.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hardware_rx.sv
// Oversampling serial bit receiver: synchronises din and re-aligns its bit window on every line edge.
// Each window is reduced to one bit by majority vote, presented on dout with a one-cycle vout strobe.
module hardware_rx #(
    parameter int SPB  = 10,
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic vout
);

    localparam int CW = $clog2(SPB + 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    localparam logic [CW-1:0] HALF = CW'(SPB / 2);
    localparam logic [CW-1:0] FULL = CW'(SPB);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [SYNC-1:0] sync_q;
    logic            s;
    logic            s_prev;
    logic            edge_s;

    logic [0:0]      state;
    logic [0:0]      state_d;
    logic [CW-1:0]   phase;
    logic [CW-1:0]   phase_d;
    logic [CW-1:0]   ones;
    logic [CW-1:0]   ones_d;

    logic [CW-1:0]   s_ext;
    logic [CW-1:0]   phase_acc;
    logic [CW-1:0]   ones_acc;
    logic            early_bit;
    logic            full_bit;
    logic            emit;
    logic            bit_d;

    assign s      = sync_q[SYNC-1];
    assign edge_s = s ^ s_prev;
    assign s_ext  = {{(CW-1){1'b0}}, s};

    assign phase_acc = phase + ONE;
    assign ones_acc  = ones + s_ext;

    // Early boundary votes over the held samples only; the edge sample belongs to the next bit.
    assign early_bit = {ones, 1'b0} > {1'b0, phase};
    assign full_bit  = {ones_acc, 1'b0} > {1'b0, FULL};

    always_comb begin
        state_d = state;
        phase_d = phase;
        ones_d  = ones;
        emit    = 1'b0;
        bit_d   = 1'b0;
        case (state)
            IDLE: begin
                if (edge_s) begin
                    state_d = RUN;
                    phase_d = ONE;
                    ones_d  = s_ext;
                end
            end
            default: begin
                if (edge_s && (phase >= HALF)) begin
                    emit    = 1'b1;
                    bit_d   = early_bit;
                    phase_d = ONE;
                    ones_d  = s_ext;
                end else if (edge_s && (phase != '0)) begin
                    // Edge too soon after the last boundary: the previous bit ran long, drop the stub.
                    phase_d = ONE;
                    ones_d  = s_ext;
                end else if (phase_acc == FULL) begin
                    emit    = 1'b1;
                    bit_d   = full_bit;
                    phase_d = '0;
                    ones_d  = '0;
                end else begin
                    phase_d = phase_acc;
                    ones_d  = ones_acc;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            s_prev <= 1'b0;
            state  <= IDLE;
            phase  <= '0;
            ones   <= '0;
            dout   <= 1'b0;
            vout   <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            s_prev <= s;
            state  <= state_d;
            phase  <= phase_d;
            ones   <= ones_d;
            vout   <= emit;
            if (emit) begin
                dout <= bit_d;
            end
        end
    end

endmodule

// File: tb/tb_hardware_rx.sv
// Bench for hardware_rx: directed pattern table with an expected-bit scoreboard, hand-written reset/latency
// sequences, and randomized runs checked cycle by cycle against a window-level reference model.
module tb_hardware_rx;

    localparam int SPB  = 10;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b0;
    logic dout;
    logic vout;

    int tests = 0;
    int fails = 0;

    hardware_rx #(.SPB(SPB), .SYNC(SYNC)) dut (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout),
        .vout (vout)
    );

    always #5 clk = ~clk;

    // Reference model: history of inputs and of the synchronised line, windows as index ranges.
    logic din_h[$];
    logic rst_h[$];
    logic s_h[$];
    int   win_start = -1;
    logic m_vout = 1'b0;
    logic m_dout = 1'b0;

    // Scoreboard for table vectors.
    logic [0:0] exp_q[$];
    bit         sb_on = 1'b0;

    typedef struct {
        string name;
        string pat;
        string exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic void emit_window(input int start, input int n);
        int cnt;
        cnt = 0;
        for (int i = start; i < start + n; i++) begin
            if (s_h[i]) cnt++;
        end
        m_vout = 1'b1;
        m_dout = (2 * cnt > n);
    endfunction

    function automatic void model_edge(input logic r, input logic d);
        int   e;
        int   held;
        logic s;
        logic sp;
        din_h.push_back(d);
        rst_h.push_back(r);
        e = din_h.size() - 1;
        // The line value reaching the decoder now was sampled SYNC edges ago, unless a reset flushed it.
        s = 1'b0;
        if (e >= SYNC) begin
            s = din_h[e-SYNC];
            for (int i = e - SYNC; i < e; i++) begin
                if (!rst_h[i]) s = 1'b0;
            end
        end
        sp = (e > 0) ? s_h[e-1] : 1'b0;
        m_vout = 1'b0;
        if (!r) begin
            win_start = -1;
            m_dout = 1'b0;
            s_h.push_back(1'b0);
            return;
        end
        s_h.push_back(s);
        if (win_start < 0) begin
            if (s != sp) win_start = e;
        end else begin
            held = e - win_start;
            if ((s != sp) && (held >= SPB / 2)) begin
                emit_window(win_start, held);
                win_start = e;
            end else if ((s != sp) && (held > 0)) begin
                win_start = e;
            end else if (held + 1 == SPB) begin
                emit_window(win_start, SPB);
                win_start = e + 1;
            end
        end
    endfunction

    task automatic step(input logic r, input logic d);
        rst = r;
        din = d;
        @(posedge clk);
        #1;
        model_edge(r, d);
        check("cycle vout", int'(vout), int'(m_vout));
        check("cycle dout", int'(dout), int'(m_dout));
        if (sb_on && vout) begin
            if (exp_q.size() == 0) check("scoreboard extra vout", 1, 0);
            else check("scoreboard bit", int'(dout), int'(exp_q.pop_front()));
        end
    endtask

    task automatic reset_dut();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    function automatic string rep(input string c, input int n);
        string r;
        r = "";
        for (int i = 0; i < n; i++) r = {r, c};
        return r;
    endfunction

    task automatic run_vec(input vec_t v);
        logic last;
        reset_dut();
        exp_q.delete();
        for (int i = 0; i < v.exp.len(); i++) exp_q.push_back(v.exp[i] == 8'h31);
        sb_on = 1'b1;
        last = 1'b0;
        for (int i = 0; i < v.pat.len(); i++) begin
            last = (v.pat[i] == 8'h31);
            step(1'b1, last);
        end
        for (int i = 0; i < SYNC; i++) step(1'b1, last);
        sb_on = 1'b0;
        check($sformatf("vec %s bits left", v.name), exp_q.size(), 0);
    endtask

    initial begin
        int   k;
        int   found;
        logic cur;
        int   run;

        vecs[0] = '{"idle_zeros",   rep("0", 50), ""};
        vecs[1] = '{"basic_1011",   {rep("0", 10), rep("1", 10), rep("0", 10), rep("1", 20)}, "1011"};
        vecs[2] = '{"early_ph9",    {rep("1", 10), "0000000001", rep("1", 10)}, "101"};
        vecs[3] = '{"late_ph3",     {rep("1", 10), rep("0", 10), "0001111111", rep("1", 20)}, "1011"};
        vecs[4] = '{"early_half",   {"1111100000", rep("0", 10)}, "10"};
        vecs[5] = '{"late_ph4",     {"1111000000", rep("0", 10)}, "0"};
        vecs[6] = '{"const_ones",   rep("1", 35), "111"};
        vecs[7] = '{"alternating",  rep("01", 15), ""};

        reset_dut();
        check("reset vout", int'(vout), 0);
        check("reset dout", int'(dout), 0);

        foreach (vecs[i]) run_vec(vecs[i]);

        // First bit on a constant line after reset: window of samples 0..SPB-1, decided SYNC edges later.
        reset_dut();
        found = -1;
        for (int i = 0; i < 40 && found < 0; i++) begin
            step(1'b1, 1'b1);
            if (vout) begin
                found = i;
                check("latency dout", int'(dout), 1);
            end
        end
        check("latency first vout step", found, SPB + SYNC - 1);

        // Reset at phase 5 of the second 1-window; relock needs SYNC refill edges plus a full window.
        reset_dut();
        for (int i = 0; i < 17; i++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        check("midreset vout", int'(vout), 0);
        check("midreset dout", int'(dout), 0);
        found = -1;
        for (int i = 1; i <= 40 && found < 0; i++) begin
            step(1'b1, 1'b1);
            if (vout) begin
                found = i;
                check("midreset relock dout", int'(dout), 1);
            end
        end
        check("midreset relock offset", found, SPB + SYNC);

        // Randomized line with runs around the bit length and occasional resets.
        reset_dut();
        cur = 1'b0;
        k = 0;
        while (k < 3000) begin
            cur = ~cur;
            run = ($urandom_range(0, 3) == 0) ? SPB * $urandom_range(1, 3) : $urandom_range(1, 2 * SPB + 5);
            for (int i = 0; i < run; i++) begin
                step(($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1, cur);
                k++;
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not complete, time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
